// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Time-multiplexed debouncer for CHANNELS independent inputs. Each input is
//   synchronized, then one shared comparator/incrementer walks all channels
//   in a sweep started by a prescaler tick. A channel's output follows its
//   synchronized input only after STABLE consecutive differing samples.
//
// Parameters
//   CHANNELS  number of filtered inputs (>= 1)
//   DIV       tick period in clk cycles; 0 = bypass (out = synchronized in, registered)
//   STABLE    consecutive differing samples needed to flip an output (>= 1)
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous, active-high reset
//   in       raw asynchronous inputs, bit i = channel i
//   out      registered filtered levels
//   change   one-cycle pulse on the bit whose out toggled (at most one high)
//   busy     high while a sweep is in progress
//   overrun  sticky: a tick arrived while a sweep was still running
//
// Build option
//   DEBOUNCE_CHANGE_EN  when defined, change pulses are generated; otherwise
//                       change is tied to 0 and out behaves identically.
module debounce_scheduler #(
    parameter int CHANNELS = 4,
    parameter int DIV      = 20,
    parameter int STABLE   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] change,
    output logic                busy,
    output logic                overrun
);

    // Two-flop synchronizer; nothing downstream ever looks at raw in.
    logic [CHANNELS-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    generate
        if (DIV == 0) begin : g_bypass
            // No filtering: one register stage after the synchronizer.
            always_ff @(posedge clk) begin
                if (rst) out <= '0;
                else     out <= sync2;
            end

            assign change  = '0;
            assign busy    = 1'b0;
            assign overrun = 1'b0;
        end else begin : g_sched
            localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
            localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
            localparam int CW  = $clog2(STABLE + 1);

            typedef enum logic {IDLE, SCAN} state_t;

            state_t                        state, state_nx;
            logic [CHW-1:0]                ch, ch_nx;
            logic [PW-1:0]                 presc;
            logic                          tick;
            logic [CHANNELS-1:0][CW-1:0]   cnt;
            logic [CHANNELS-1:0]           out_r;
            logic                          ovr_r;
            logic                          diff, hit;
            logic [CW-1:0]                 cnt_inc;

            // Free-running prescaler; tick marks the DIV-1 -> 0 wrap.
            assign tick = (presc == PW'(DIV - 1));

            always_ff @(posedge clk) begin
                if (rst)       presc <= '0;
                else if (tick) presc <= '0;
                else           presc <= presc + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= IDLE;
                    ch    <= '0;
                end else begin
                    state <= state_nx;
                    ch    <= ch_nx;
                end
            end

            // Ticks seen in SCAN are dropped here; they only feed overrun.
            always_comb begin
                state_nx = state;
                ch_nx    = ch;
                busy     = 1'b0;
                case (state)
                    IDLE: begin
                        if (tick) begin
                            state_nx = SCAN;
                            ch_nx    = '0;
                        end
                    end
                    SCAN: begin
                        busy = 1'b1;
                        if (ch == CHW'(CHANNELS - 1)) begin
                            state_nx = IDLE;
                            ch_nx    = '0;
                        end else begin
                            ch_nx = ch + 1'b1;
                        end
                    end
                    default: begin
                        state_nx = IDLE;
                        ch_nx    = '0;
                    end
                endcase
            end

            // Shared slot datapath: only channel ch is looked at this cycle.
            // cnt never holds STABLE, so cnt_inc always fits in CW bits.
            assign diff    = sync2[ch] ^ out_r[ch];
            assign cnt_inc = cnt[ch] + CW'(1);
            assign hit     = diff && (cnt_inc == CW'(STABLE));

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt   <= '0;
                    out_r <= '0;
                    ovr_r <= 1'b0;
                end else begin
                    if (state == SCAN && tick) ovr_r <= 1'b1;
                    if (state == SCAN) begin
                        // Any agreeing sample wipes the run: no partial credit.
                        if (!diff) begin
                            cnt[ch] <= '0;
                        end else if (hit) begin
                            cnt[ch]   <= '0;
                            out_r[ch] <= sync2[ch];
                        end else begin
                            cnt[ch] <= cnt_inc;
                        end
                    end
                end
            end

            assign out     = out_r;
            assign overrun = ovr_r;

`ifdef DEBOUNCE_CHANGE_EN
            // One slot per cycle means at most one bit is ever set here.
            logic [CHANNELS-1:0] chg_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chg_r <= '0;
                end else begin
                    chg_r <= '0;
                    if (state == SCAN && hit) chg_r[ch] <= 1'b1;
                end
            end

            assign change = chg_r;
`else
            assign change = '0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler. Three instances share clk, rst
// and in: the main one (DIV=8), a fast-tick one (DIV=3) that must overrun,
// and a bypass one (DIV=0). Each is compared every cycle with a timestamp
// based reference model: ticks fall on edge numbers that are multiples of
// DIV, and a sweep started at edge s looks at channel c on edge s+1+c.
module tb_debounce_scheduler;

    localparam int N      = 4;
    localparam int NI     = 3;
    localparam int STABLE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_v = '0;

    logic [N-1:0] out0, out1, out2, chg0, chg1, chg2;
    logic         busy0, busy1, busy2, ovr0, ovr1, ovr2;

    always #5 clk = ~clk;

    debounce_scheduler #(.CHANNELS(N), .DIV(8), .STABLE(STABLE)) u_main (
        .clk(clk), .rst(rst), .in(in_v), .out(out0), .change(chg0),
        .busy(busy0), .overrun(ovr0));

    debounce_scheduler #(.CHANNELS(N), .DIV(3), .STABLE(STABLE)) u_fast (
        .clk(clk), .rst(rst), .in(in_v), .out(out1), .change(chg1),
        .busy(busy1), .overrun(ovr1));

    debounce_scheduler #(.CHANNELS(N), .DIV(0), .STABLE(STABLE)) u_byp (
        .clk(clk), .rst(rst), .in(in_v), .out(out2), .change(chg2),
        .busy(busy2), .overrun(ovr2));

    logic [N-1:0] d_out [NI];
    logic [N-1:0] d_chg [NI];
    logic         d_busy[NI];
    logic         d_ovr [NI];

    assign d_out[0] = out0;   assign d_out[1] = out1;   assign d_out[2] = out2;
    assign d_chg[0] = chg0;   assign d_chg[1] = chg1;   assign d_chg[2] = chg2;
    assign d_busy[0] = busy0; assign d_busy[1] = busy1; assign d_busy[2] = busy2;
    assign d_ovr[0] = ovr0;   assign d_ovr[1] = ovr1;   assign d_ovr[2] = ovr2;

    // Reference model state
    int           divs[NI] = '{8, 3, 0};
    int           k;                 // edges since reset released
    int           sw_start[NI];      // edge at which the latest sweep began
    int           m_cnt[NI][N];
    logic [N-1:0] m_out[NI];
    logic [N-1:0] m_chg[NI];
    logic         m_ovr[NI];
    logic [N-1:0] hist1, hist2;      // in as sampled on the last two edges

    int n_tot = 0;
    int n_bad = 0;
    int pulse_bits = 0;              // change bits seen on u_main

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] sy;
        int c;
        if (rst) begin
            k = 0;
            hist1 = '0;
            hist2 = '0;
            for (int i = 0; i < NI; i++) begin
                m_out[i] = '0;
                m_chg[i] = '0;
                m_ovr[i] = 1'b0;
                sw_start[i] = -1000;
                for (int b = 0; b < N; b++) m_cnt[i][b] = 0;
            end
        end else begin
            k++;
            sy = hist2;
            for (int i = 0; i < NI; i++) begin
                m_chg[i] = '0;
                if (divs[i] == 0) begin
                    m_out[i] = sy;
                end else begin
                    if (k > sw_start[i] && k <= sw_start[i] + N) begin
                        c = k - sw_start[i] - 1;
                        if (sy[c] == m_out[i][c]) begin
                            m_cnt[i][c] = 0;
                        end else if (m_cnt[i][c] + 1 >= STABLE) begin
                            m_out[i][c] = sy[c];
                            m_cnt[i][c] = 0;
                            m_chg[i][c] = 1'b1;
                        end else begin
                            m_cnt[i][c]++;
                        end
                    end
                    if (k % divs[i] == 0) begin
                        if (k > sw_start[i] && k <= sw_start[i] + N) m_ovr[i] = 1'b1;
                        else sw_start[i] = k;
                    end
                end
            end
            hist2 = hist1;
            hist1 = in_v;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] ec;
        logic         eb;
        for (int i = 0; i < NI; i++) begin
            ec = m_chg[i];
`ifndef DEBOUNCE_CHANGE_EN
            ec = '0;
`endif
            eb = (divs[i] != 0) && (k >= sw_start[i]) && (k < sw_start[i] + N);
            chk($sformatf("out%0d", i),    32'(d_out[i]),  32'(m_out[i]));
            chk($sformatf("change%0d", i), 32'(d_chg[i]),  32'(ec));
            chk($sformatf("busy%0d", i),   32'(d_busy[i]), 32'(eb));
            chk($sformatf("overrun%0d", i), 32'(d_ovr[i]), 32'(m_ovr[i]));
            chk($sformatf("onehot%0d", i), 32'($countones(d_chg[i]) <= 1), 32'(1));
        end
        pulse_bits += $countones(d_chg[0]);
    endtask

    task automatic cyc(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        int exp_pulses;
        int b;
`ifdef DEBOUNCE_CHANGE_EN
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        // Reset with all inputs high, then one cycle released with in still high.
        rst  = 1'b1;
        in_v = '1;
        cyc(5);
        rst = 1'b0;
        cyc(1);
        chk("rel_out0", 32'(out0), 32'(0));
        in_v = '0;
        cyc(40);

        // Clean step on channel 2.
        pulse_bits = 0;
        in_v[2] = 1'b1;
        cyc(60);
        chk("step_out", 32'(out0), 32'(4'b0100));
        chk("step_pulses", 32'(pulse_bits), 32'(exp_pulses));
        chk("ovr_sticky", 32'(ovr1), 32'(1));

        // Glitch on channel 0: high for two sweeps, twice, never accepted.
        for (int r = 0; r < 2; r++) begin
            in_v[0] = 1'b1;
            cyc(16);
            in_v[0] = 1'b0;
            cyc(24);
        end
        chk("glitch_out0", 32'(out0[0]), 32'(0));

        // All channels step together.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        in_v = '0;
        cyc(20);
        pulse_bits = 0;
        in_v = '1;
        cyc(60);
        chk("simul_out", 32'(out0), 32'(4'b1111));
        chk("simul_pulses", 32'(pulse_bits), 32'(4 * exp_pulses));

        // Reset in the middle of a sweep.
        in_v = '0;
        cyc(11);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(30);

        // Random bouncing with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                b = $urandom_range(0, N - 1);
                in_v[b] = ~in_v[b];
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(40);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent filtered inputs, minimum 1.
REQ-002 SHALL have parameter DIV, default 20: sampling-tick period in clk cycles; 0 selects bypass.
REQ-003 SHALL have parameter STABLE, default 3: consecutive differing samples required to update an output, minimum 1.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  input  CHANNELS  raw asynchronous inputs, bit i = channel i.
REQ-007 SHALL have port out  output  CHANNELS  registered filtered levels.
REQ-008 SHALL have port change  output  CHANNELS  one-cycle pulse per channel when its out bit toggles.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port overrun  output  1  sticky: a tick arrived during a sweep.

Function
REQ-011 SHALL pass every in bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL use a single shared prescaler counting 0..DIV-1 that emits a one-cycle tick on the wrap from DIV-1 to 0.
REQ-013 SHALL use a two-state FSM: IDLE -> SCAN on tick; in SCAN, index ch advances 0..CHANNELS-1, one channel per cycle; SCAN -> IDLE after ch = CHANNELS-1.
REQ-014 SHALL drive busy high exactly in the SCAN state.
REQ-015 SHALL evaluate only channel ch in each SCAN cycle, using a shared comparator and incrementer for all channels.
REQ-016 SHALL clear cnt[ch] when sync[ch] equals out[ch].
REQ-017 SHALL increment cnt[ch] when sync[ch] differs from out[ch].
REQ-018 SHALL, when that increment would reach STABLE, load out[ch] with sync[ch], clear cnt[ch], and pulse change[ch] in the next cycle.
REQ-019 SHALL size each cnt to $clog2(STABLE+1) bits; cnt shall never exceed STABLE-1.
REQ-020 SHALL ignore a tick that arrives while in SCAN, leave the current sweep unaffected, and set overrun, which stays high until rst.
REQ-021 SHALL ensure that at most one change bit is high in any cycle.
REQ-022 SHALL, when DIV == 0, drive out = synchronized in with 1 registered stage, hold busy, overrun and change at 0, and instantiate no FSM.
REQ-023 SHALL treat a channel whose input bounces mid-count as restarting from zero, with no partial credit.

Reset
REQ-024 SHALL, while rst is high, force out, change, cnt, synchronizers, prescaler, ch and overrun to 0, force busy to 0, and force the state to IDLE.
REQ-025 SHALL, on rst asserted mid-sweep, abandon the sweep; the first tick after release occurs DIV cycles after rst deasserts.

Configuration
REQ-026 SHALL honour the macro DEBOUNCE_CHANGE_EN: when defined, change behaves per REQ-018 and REQ-021.
REQ-027 SHALL, when DEBOUNCE_CHANGE_EN is undefined, keep the change port but tie it to 0 and synthesize no change-pulse logic; out behaviour is identical.

Verification (CHANNELS=4, DIV=8, STABLE=3 unless stated)
REQ-028 SHALL cover reset: hold rst 5 cycles with in=4'b1111 -> out=0, busy=0, overrun=0, change=0 throughout and on the cycle after release.
REQ-029 SHALL cover a clean step: in[2] 0->1 and held -> out[2] rises during the 3rd sweep after the synchronized value appears, in the cycle after slot ch=2; change[2] pulses once; other bits unchanged.
REQ-030 SHALL cover a glitch: in[0] high for exactly 2 sweeps, then low -> out[0] stays 0, change stays 0, and cnt[0] returns to 0.
REQ-031 SHALL cover simultaneous events: in 0000->1111 held -> out bits set in consecutive cycles (bit0..bit3) within one sweep; change pulses are one-hot, each in a distinct cycle.
REQ-032 SHALL cover overrun: DIV=3, CHANNELS=4 -> overrun rises on the first tick inside SCAN, stays 1 until rst, and sweeps still complete all 4 slots.
REQ-033 SHALL cover bypass and the compile option: DIV=0 -> out follows in with 3 cycles total latency; a build without DEBOUNCE_CHANGE_EN re-running REQ-029 -> same out, change always 0.
